// File: rtl/btb_pc_fetch.sv
// IF-stage fetch-address generator: PC register plus a direct-mapped BTB
// with a 2-bit saturating direction counter per entry.
// Optional macro BTB_STATS_EN adds stat_branches / stat_mispredicts counters.
module btb_pc_fetch #(
  parameter int unsigned ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubbleF,
  input  logic        flushF,
  output logic [31:0] PC_IF,
  output logic [31:0] NPC_IF,
  output logic        pred_taken_IF,
  input  logic        update_EX,
  input  logic [31:0] PC_EX,
  input  logic        taken_EX,
  input  logic [31:0] target_EX,
  input  logic        redirect_EX,
  input  logic [31:0] redirect_PC_EX
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TagW = 30 - IDX;

  logic [31:0]        pc_q, pc_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TagW-1:0]    tag_q    [ENTRIES];
  logic [TagW-1:0]    tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [IDX-1:0]  rd_idx, wr_idx;
  logic [TagW-1:0] rd_tag, wr_tag;
  logic            rd_hit, wr_hit;

  // Byte-offset bits of the resolved PC never index the BTB.
  logic unused_pc_ex_lsb;
  assign unused_pc_ex_lsb = ^PC_EX[1:0];

  assign rd_idx = pc_q[IDX+1:2];
  assign rd_tag = pc_q[31:IDX+2];
  assign wr_idx = PC_EX[IDX+1:2];
  assign wr_tag = PC_EX[31:IDX+2];
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Prediction from pre-update BTB contents.
  always_comb begin
    pred_taken_IF = rd_hit && ctr_q[rd_idx][1];
    NPC_IF        = pred_taken_IF ? target_q[rd_idx] : pc_q + 32'd4;
  end

  assign PC_IF = pc_q;

  // PC next state: EX redirect beats flush, flush beats stall.
  always_comb begin
    if (redirect_EX)  pc_d = redirect_PC_EX;
    else if (flushF)  pc_d = RESET_PC;
    else if (bubbleF) pc_d = pc_q;
    else              pc_d = NPC_IF;
  end

  // BTB training from the EX-stage resolution.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (update_EX) begin
      if (wr_hit) begin
        if (taken_EX) begin
          if (ctr_q[wr_idx] != 2'b11) ctr_d[wr_idx] = ctr_q[wr_idx] + 2'b01;
          target_d[wr_idx] = target_EX;
        end else if (ctr_q[wr_idx] != 2'b00) begin
          ctr_d[wr_idx] = ctr_q[wr_idx] - 2'b01;
        end
      end else if (taken_EX) begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = target_EX;
        ctr_d[wr_idx]    = 2'b10;
      end
    end
  end

  // State registers; reset suppresses any training in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Event counters, free-running and wrapping.
  always_comb begin
    stat_branches_d    = stat_branches_q + {31'd0, update_EX};
    stat_mispredicts_d = stat_mispredicts_q + {31'd0, redirect_EX};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_btb_pc_fetch.sv
// Bench for btb_pc_fetch: directed plan cases with literal expectations,
// then randomized traffic against a behavioural BTB/PC model.
module tb_btb_pc_fetch;

  localparam int NENT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bubbleF = 1'b0, flushF = 1'b0;
  logic        update_EX = 1'b0, taken_EX = 1'b0, redirect_EX = 1'b0;
  logic [31:0] PC_EX = '0, target_EX = '0, redirect_PC_EX = '0;
  logic [31:0] PC_IF, NPC_IF;
  logic        pred_taken_IF;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  btb_pc_fetch #(.ENTRIES(NENT), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .bubbleF        (bubbleF),
    .flushF         (flushF),
    .PC_IF          (PC_IF),
    .NPC_IF         (NPC_IF),
    .pred_taken_IF  (pred_taken_IF),
    .update_EX      (update_EX),
    .PC_EX          (PC_EX),
    .taken_EX       (taken_EX),
    .target_EX      (target_EX),
    .redirect_EX    (redirect_EX),
    .redirect_PC_EX (redirect_PC_EX)
`ifdef BTB_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  bit          m_known = 0;
  logic [31:0] m_pc;
  bit          m_valid [NENT];
  logic [31:0] m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  logic [31:0] m_nbr, m_nmis;

  function automatic bit m_pred(input logic [31:0] pc);
    int i = int'((pc >> 2) % NENT);
    return m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    int i = int'((pc >> 2) % NENT);
    return m_pred(pc) ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against model, then advance the model.
  task automatic cycle(input bit r, input bit b, input bit f, input bit u,
                       input logic [31:0] pe, input bit tk, input logic [31:0] tg,
                       input bit rd, input logic [31:0] rp);
    logic [31:0] npc;
    int i;
    @(negedge clk);
    rst = r; bubbleF = b; flushF = f; update_EX = u; PC_EX = pe;
    taken_EX = tk; target_EX = tg; redirect_EX = rd; redirect_PC_EX = rp;
    #1;
    if (m_known) begin
      chk("pc_if", PC_IF, m_pc);
      chk("npc_if", NPC_IF, m_next(m_pc));
      chk("pred_taken", {31'd0, pred_taken_IF}, {31'd0, m_pred(m_pc)});
`ifdef BTB_STATS_EN
      chk("stat_branches", stat_branches, m_nbr);
      chk("stat_mispredicts", stat_mispredicts, m_nmis);
`endif
    end
    @(posedge clk);
    npc = m_next(m_pc);
    if (r) begin
      m_known = 1;
      m_pc = 32'h0; m_nbr = 0; m_nmis = 0;
      for (int k = 0; k < NENT; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
      end
    end else begin
      m_pc = rd ? rp : (f ? 32'h0 : (b ? m_pc : npc));
      if (u) begin
        i = int'((pe >> 2) % NENT);
        if (m_valid[i] && m_tag[i] == (pe >> 6)) begin
          if (tk) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = tg;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (tk) begin
          m_valid[i] = 1; m_tag[i] = pe >> 6; m_tgt[i] = tg; m_ctr[i] = 2;
        end
      end
      if (u)  m_nbr  = m_nbr + 1;
      if (rd) m_nmis = m_nmis + 1;
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Train an entry while steering fetch to a chosen PC.
  task automatic train(input logic [31:0] pe, input bit tk, input logic [31:0] tg,
                       input logic [31:0] rp);
    cycle(0, 0, 0, 1, pe, tk, tg, 1, rp);
  endtask

  initial begin
    // Reset and free-run.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", PC_IF, 32'h0);
    chk("rst_npc", NPC_IF, 32'h4);
    chk("rst_pred", {31'd0, pred_taken_IF}, 32'd0);
    idle(); chk("run_pc1", PC_IF, 32'h4);
    idle(); chk("run_pc2", PC_IF, 32'h8);

    // Allocate 0x10 -> 0x40 on a taken miss.
    cycle(0, 0, 0, 1, 32'h10, 1, 32'h40, 0, 0);
    chk("alloc_pc", PC_IF, 32'hC);
    idle();
    chk("alloc_at10", PC_IF, 32'h10);
    chk("alloc_npc", NPC_IF, 32'h40);
    chk("alloc_pred", {31'd0, pred_taken_IF}, 32'd1);
    idle(); chk("alloc_jump", PC_IF, 32'h40);

    // Not-taken training down to saturation.
    train(32'h10, 0, 0, 32'h100);
    train(32'h10, 0, 0, 32'h10);
    chk("nt_npc", NPC_IF, 32'h14);
    chk("nt_pred", {31'd0, pred_taken_IF}, 32'd0);
    train(32'h10, 0, 0, 32'h10);
    train(32'h10, 1, 32'h40, 32'h10);
    chk("sat_pred", {31'd0, pred_taken_IF}, 32'd0);

    // Alias: 0x50 shares index 4 with 0x10.
    train(32'h10, 1, 32'h40, 32'h300);
    train(32'h50, 1, 32'h80, 32'h10);
    chk("alias_old_npc", NPC_IF, 32'h14);
    chk("alias_old_pred", {31'd0, pred_taken_IF}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h50);
    chk("alias_new_npc", NPC_IF, 32'h80);
    chk("alias_new_pred", {31'd0, pred_taken_IF}, 32'd1);

    // Next-PC priority.
    cycle(0, 1, 1, 0, 0, 0, 0, 1, 32'h200);
    chk("prio_redirect", PC_IF, 32'h200);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("prio_flush", PC_IF, 32'h0);
    idle();
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("prio_bubble", PC_IF, 32'h4);

    // Reset wins over concurrent training.
    cycle(1, 0, 0, 1, 32'h0, 1, 32'h500, 1, 32'h600);
    chk("rst_upd_pc", PC_IF, 32'h0);
    chk("rst_upd_pred", {31'd0, pred_taken_IF}, 32'd0);

`ifdef BTB_STATS_EN
    for (int k = 0; k < 5; k++)
      cycle(0, 0, 0, 1, 32'h20, k[0], 32'h80, (k < 2), 32'h0);
    chk("stat_br5", stat_branches, 32'd5);
    chk("stat_mis2", stat_mispredicts, 32'd2);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stat_br_rst", stat_branches, 32'd0);
    chk("stat_mis_rst", stat_mispredicts, 32'd0);
`endif

    // Randomized traffic over a small address region so hits and aliases occur.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pe, tg, rp;
      pe = {23'd0, $urandom_range(0, 127), 2'b00};
      tg = {24'd0, $urandom_range(0, 63), 2'b00};
      rp = {23'd0, $urandom_range(0, 127), 2'b00};
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 4),
            pe, $urandom_range(0, 1) == 1, tg, ($urandom_range(0, 9) == 0), rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
